mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//  Iterative signed multiply/divide unit for the multicycle CPU. Consumes the A/B register
//  operands and produces the HI and LO values feeding the register write-data mux (mfhi/mflo).
//  The control unit issues a start pulse, waits on busy/done, and routes div_zero to its
//  exception path.
// PARAMETERS
//  WIDTH   32  operand width; hi/lo are WIDTH each; iteration count = WIDTH
// PORTS
//  clock     in   1      system clock, rising edge
//  reset     in   1      synchronous, active-high
//  start     in   1      1-cycle request; sampled only in IDLE
//  op_div    in   1      0 = mult (signed), 1 = div (signed); sampled with start
//  op_a      in   WIDTH  multiplicand / dividend (reg A)
//  op_b      in   WIDTH  multiplier / divisor (reg B)
//  busy      out  1      high while state != IDLE
//  done      out  1      1-cycle pulse: hi/lo hold the new result
//  div_zero  out  1      1-cycle pulse with done when a div has op_b == 0
//  hi        out  WIDTH  mult: product[63:32]; div: remainder
//  lo        out  WIDTH  mult: product[31:0];  div: quotient
// BEHAVIOUR
//  - Clock and reset: single clock domain. Reset is synchronous and active-high.
//  - Reset values: state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, iteration counter=0.
//  - FSM states are IDLE, CALC and DONE.
//  - IDLE -> CALC: on an edge E0 with start=1. Latch op_div, |op_a| and |op_b|, both result
//    signs, and the counter at WIDTH-1.
//  - IDLE -> DONE: on E0 with start=1 and op_div=1 and op_b==0. div_zero=1 in DONE. hi/lo are
//    left unchanged. No CALC cycles are spent.
//  - CALC: performs one iteration per edge, E0+1 .. E0+WIDTH.
//      mult: shift-add on magnitudes into a 2*WIDTH accumulator.
//      div: restoring step on magnitudes; partial remainder is WIDTH+1 bits.
//  - CALC -> DONE: on the edge where the counter is 0. On that same edge hi/lo load the
//    sign-corrected result.
//  - DONE: done=1 for exactly one cycle, then IDLE on the next edge.
//  - Latency: the done pulse begins WIDTH edges after E0 (32 for the default), or 1 edge after
//    E0 for divide-by-zero.
//  - Sign rules:
//      mult: product is negated iff op_a[MSB] ^ op_b[MSB].
//      div: quotient truncates toward zero. Quotient is negated iff the signs differ.
//      Remainder takes the sign of the dividend, and |rem| < |divisor|.
//  - Boundary cases:
//      0x80000000 * 0x80000000 -> HI=0x40000000, LO=0.
//      0x80000000 / -1 -> LO=0x80000000, HI=0. No trap; overflow is ignored.
//  - start while busy (CALC or DONE) is ignored. It is not queued.
//  - op_a, op_b and op_div may change freely after E0. Only the latched copies are used.
//  - hi/lo hold their value between operations. They change only on CALC -> DONE or on reset.
//  - reset mid-CALC: the operation is aborted. Next cycle: IDLE, busy=0, hi=lo=0, no done pulse.
//  - reset and start on the same edge: reset wins and start is dropped.
// STRUCTURE
//  - Shared include mult_div_defs.vh holds these localparams:
//      MD_IDLE, MD_CALC and MD_DONE state codes;
//      MD_OP_MULT = 1'b0 and MD_OP_DIV = 1'b1.
//    It is also used by control_Unit for op encoding.
//  - One sub-module, div_restore_step: purely combinational, one restoring-division iteration.
//      inputs: partial remainder, divisor, next dividend bit
//      outputs: new remainder, quotient bit
//  - The multiply iteration, magnitude/negate logic, counter and FSM live in mult_div_unit.
// TESTING
//  1. mult 7 x 0xFFFFFFFD (-3) -> done at E0+32; HI=0xFFFFFFFF, LO=0xFFFFFFEB; div_zero=0.
//  2. mult 0x7FFFFFFF x 0x7FFFFFFF -> HI=0x3FFFFFFF, LO=0x00000001.
//     Also 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
//  3. div 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
//     Also 7 / 0xFFFFFFFE -> LO=0xFFFFFFFD, HI=1.
//  4. div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; no div_zero.
//  5. preload HI/LO via mult 3x5 (HI=0, LO=15), then div 9/0 -> done and div_zero at E0+1;
//     HI=0, LO=15 unchanged; busy low by E0+2.
//  6. start mult 6x7; assert reset at E0+10 -> busy=0, hi=lo=0, no done; pulse start again
//     while busy is checked to be ignored; fresh 6x7 -> LO=42 at +32.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: shared state and op encodings for the multiply/divide unit
package mult_div_unit_pkg;
  typedef enum logic [1:0] {MD_IDLE = 2'd0, MD_CALC = 2'd1, MD_DONE = 2'd2} md_state_e;
  localparam logic MD_OP_MULT = 1'b0;
  localparam logic MD_OP_DIV = 1'b1;
endpackage

// File: rtl/mult_div_unit_div_restore_step.sv
// div_restore_step: one combinational restoring-division iteration on magnitudes
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dividend_bit,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);
  logic [WIDTH:0] shifted, diff;
  always_comb begin
    shifted = {rem_in, dividend_bit};
    diff = shifted - {1'b0, divisor};
    q_bit = shifted >= {1'b0, divisor};
    rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed multiply/divide, one bit per cycle on operand magnitudes
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  md_state_e state, state_nxt;
  logic [CW-1:0] cnt;
  logic is_div, neg, a_neg, dz, q_bit, go, go_zero, last;
  logic [WIDTH-1:0] mag_b, rem, rem_nxt, quo, rmd;
  logic [WIDTH:0] sum;
  logic [2*WIDTH-1:0] acc, acc_nxt, prod;
  assign go = state == MD_IDLE && start;
  assign go_zero = go && op_div == MD_OP_DIV && op_b == '0;
  assign last = state == MD_CALC && cnt == '0;
  assign busy = state != MD_IDLE;
  assign done = state == MD_DONE;
  assign div_zero = done && dz;
  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem_in(rem),
    .divisor(mag_b),
    .dividend_bit(acc[WIDTH-1]),
    .rem_out(rem_nxt),
    .q_bit(q_bit)
  );
  // Multiply: low half holds the remaining multiplier bits, high half accumulates.
  // Divide: low half shifts the dividend out and the quotient in.
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? mag_b : {WIDTH{1'b0}}};
    acc_nxt = is_div ? {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], q_bit} : {sum, acc[WIDTH-1:1]};
    prod = neg ? -acc_nxt : acc_nxt;
    quo = neg ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
    rmd = a_neg ? -rem_nxt : rem_nxt;
  end
  always_comb
    state_nxt = state == MD_IDLE ? (go_zero ? MD_DONE : go ? MD_CALC : MD_IDLE) :
                state == MD_CALC ? (cnt == '0 ? MD_DONE : MD_CALC) : MD_IDLE;
  always_ff @(posedge clock)
    state <= reset ? MD_IDLE : state_nxt;
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
      is_div <= 1'b0;
      neg <= 1'b0;
      a_neg <= 1'b0;
      dz <= 1'b0;
      mag_b <= '0;
      rem <= '0;
      acc <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      if (go) begin
        cnt <= CW'(WIDTH - 1);
        is_div <= op_div;
        neg <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
        a_neg <= op_a[WIDTH-1];
        dz <= go_zero;
        mag_b <= op_b[WIDTH-1] ? -op_b : op_b;
        rem <= '0;
        acc <= {{WIDTH{1'b0}}, op_a[WIDTH-1] ? -op_a : op_a};
      end else if (state == MD_CALC) begin
        cnt <= cnt - 1'b1;
        rem <= rem_nxt;
        acc <= acc_nxt;
      end
      if (last) begin
        hi <= is_div ? rmd : prod[2*WIDTH-1:WIDTH];
        lo <= is_div ? quo : prod[WIDTH-1:0];
      end
    end
  end
endmodule
